robber_tx_uart: RTL and testbench

- Downstream stage of the robber_language core. Consumes the core's output byte stream (data_out, data_out_valid) and transmits it over an 8N1 serial line.
- The core has no output backpressure and can emit up to 3 bytes per input byte. This block absorbs bursts in a byte FIFO.
- It raises almost_full so the upstream controller can hold data_in_valid to the core.

---
 rtl/robber_tx_uart.sv | 142 ++++++++++++++
 tb/tb_robber_tx_uart.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/robber_tx_uart.sv
// Byte FIFO plus 8N1 serial transmitter for the robber_language core output stream.
// almost_full lets the upstream controller stall the core before a worst-case expansion overflows the FIFO.
module robber_tx_uart #(
  parameter int DEPTH     = 16,
  parameter int CLK_DIV   = 868,
  parameter int AF_MARGIN = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               data_in,
  input  logic                     data_in_valid,
  input  logic                     clear_overflow,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     tx_busy,
  output logic                     txd
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(DEPTH - AF_MARGIN);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_af, r_ovf;
  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd, r_busy;

  logic          w_pop, w_wr, w_drop, w_tick;
  logic [LW-1:0] w_level_nxt;

  // A full FIFO still accepts a byte when the head is leaving in the same cycle.
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
  assign w_wr   = data_in_valid && ((r_level != LVL_FULL) || w_pop);
  assign w_drop = data_in_valid && !w_wr;
  assign w_tick = (r_div == DIV_LAST);

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (!w_wr && w_pop) w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_af    <= (w_level_nxt >= LVL_AF);
      // A fresh drop beats a simultaneous clear.
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_div   <= '0;
            r_state <= S_START;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_txd   <= r_shift[0];
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_div <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_div   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign almost_full = r_af;
  assign overflow    = r_ovf;
  assign fifo_level  = r_level;
  assign tx_busy     = r_busy;
  assign txd         = r_txd;

endmodule

// File: tb/tb_robber_tx_uart.sv
// Directed bench for robber_tx_uart with CLK_DIV=4; a negedge line monitor captures each 40-cycle frame.
module tb_robber_tx_uart;

  localparam int DEPTH = 16;
  localparam int CDIV  = 4;
  localparam int AFM   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       almost_full, overflow, tx_busy, txd;
  logic [4:0] fifo_level;

  int n_chk = 0;
  int n_fail = 0;

  robber_tx_uart #(.DEPTH(DEPTH), .CLK_DIV(CDIV), .AF_MARGIN(AFM)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear_overflow(clear_overflow), .almost_full(almost_full), .overflow(overflow),
    .fifo_level(fifo_level), .tx_busy(tx_busy), .txd(txd)
  );

  always #5 clk = ~clk;

  // Line monitor: one wave sample per cycle, 40 samples per frame from the falling start edge.
  logic [39:0] rx_wave[$];
  int          rx_t0[$];
  int          cyc = 0;
  bit          mon_act = 0;
  int          mon_t0 = 0;
  logic [39:0] mon_wave;

  always @(negedge clk) begin
    if (reset) begin
      mon_act = 0;
    end else if (!mon_act) begin
      if (txd === 1'b0) begin
        mon_act = 1;
        mon_t0 = cyc;
        mon_wave = '0;
        mon_wave[0] = txd;
      end
    end else begin
      mon_wave[cyc - mon_t0] = txd;
      if (cyc - mon_t0 == 39) begin
        rx_wave.push_back(mon_wave);
        rx_t0.push_back(mon_t0);
        mon_act = 0;
      end
    end
    cyc++;
  end

  function automatic logic [7:0] wave_byte(input logic [39:0] w);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = w[4*(k+1)+2];
    return b;
  endfunction

  function automatic logic [39:0] frame_wave(input logic [7:0] b);
    logic [39:0] w;
    logic [9:0]  bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) w[i] = bits[i/4];
    return w;
  endfunction

  task automatic wait_frames(input int n, input int budget, input string name);
    int t = 0;
    while (rx_wave.size() < n && t < budget) begin
      @(posedge clk); #1; t++;
    end
    n_chk++;
    if (rx_wave.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout frames=%0d want=%0d", name, rx_wave.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b want=1", txd); end
    n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
    n_chk++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    n_chk++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b want=0", almost_full); end
  endtask

  task automatic test_single;
    int n = 0;
    int base = rx_wave.size();
    @(negedge clk); data_in = 8'h6F; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in_valid = 1'b0;
    n_chk++; if (fifo_level !== 5'd1 || txd !== 1'b1) begin n_fail++; $display("FAIL single_write level=%0d txd=%b want 1/1", fifo_level, txd); end
    @(posedge clk); #1;
    n_chk++; if (txd !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_fall txd=%b busy=%b want 0/1", txd, tx_busy); end
    n_chk++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL single_pop level=%0d want=0", fifo_level); end
    while (tx_busy && n < 100) begin @(posedge clk); #1; n++; end
    n_chk++; if (n != 40) begin n_fail++; $display("FAIL single_busy_len got=%0d want=40", n); end
    wait_frames(base + 1, 10, "single_frame");
    if (rx_wave.size() > base) begin
      n_chk++;
      if (rx_wave[base] !== frame_wave(8'h6F)) begin
        n_fail++; $display("FAIL single_wave got=%h want=%h", rx_wave[base], frame_wave(8'h6F));
      end
    end
  endtask

  task automatic test_burst;
    logic [7:0] bob[3] = '{8'h62, 8'h6F, 8'h62};
    int peak = 0;
    int t = 0;
    int base = rx_wave.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); data_in = bob[i]; data_in_valid = 1'b1;
      @(posedge clk); #1; data_in_valid = 1'b0;
      if (fifo_level > peak) peak = fifo_level;
    end
    while (rx_wave.size() < base + 3 && t < 200) begin
      @(posedge clk); #1; t++;
      if (fifo_level > peak) peak = fifo_level;
    end
    n_chk++; if (peak != 2) begin n_fail++; $display("FAIL burst_peak got=%0d want=2", peak); end
    n_chk++;
    if (rx_wave.size() < base + 3) begin
      n_fail++; $display("FAIL burst_frames got=%0d want=%0d", rx_wave.size() - base, 3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (rx_wave[base+i] !== frame_wave(bob[i])) begin
          n_fail++; $display("FAIL burst_wave%0d got=%h want=%h", i, rx_wave[base+i], frame_wave(bob[i]));
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_chk++;
        if (rx_t0[base+i] - rx_t0[base+i-1] != 41) begin
          n_fail++; $display("FAIL burst_gap%0d got=%0d want=41", i, rx_t0[base+i] - rx_t0[base+i-1]);
        end
      end
      n_chk++;
      if (rx_t0[base+2] + 40 - rx_t0[base] != 122) begin
        n_fail++; $display("FAIL burst_total got=%0d want=122", rx_t0[base+2] + 40 - rx_t0[base]);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_fill_overflow;
    int af_lvl = -1;
    int base = rx_wave.size();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); data_in = 8'(i); data_in_valid = 1'b1;
      @(posedge clk); #1; data_in_valid = 1'b0;
      if (almost_full && af_lvl < 0) af_lvl = fifo_level;
    end
    n_chk++; if (af_lvl != 13) begin n_fail++; $display("FAIL fill_af_level got=%0d want=13", af_lvl); end
    n_chk++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_full level=%0d ovf=%b want 16/0", fifo_level, overflow); end
    @(negedge clk); data_in = 8'h11; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in_valid = 1'b0;
    n_chk++; if (overflow !== 1'b1 || fifo_level !== 5'd16) begin n_fail++; $display("FAIL fill_drop ovf=%b level=%0d want 1/16", overflow, fifo_level); end
    repeat (4) @(posedge clk); #1;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_sticky got=%b want=1", overflow); end
    @(negedge clk); data_in = 8'h12; data_in_valid = 1'b1; clear_overflow = 1'b1;
    @(posedge clk); #1; data_in_valid = 1'b0; clear_overflow = 1'b0;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_clear_vs_drop got=%b want=1", overflow); end
    @(negedge clk); clear_overflow = 1'b1;
    @(posedge clk); #1; clear_overflow = 1'b0;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_clear got=%b want=0", overflow); end
    wait_frames(base + 17, 17*41 + 100, "fill_frames");
    repeat (60) @(posedge clk); #1;
    n_chk++; if (rx_wave.size() != base + 17) begin n_fail++; $display("FAIL fill_count got=%0d want=17", rx_wave.size() - base); end
    n_chk++; if (almost_full !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL fill_drain af=%b level=%0d want 0/0", almost_full, fifo_level); end
    for (int i = 0; i < 17 && base + i < rx_wave.size(); i++) begin
      n_chk++;
      if (wave_byte(rx_wave[base+i]) !== 8'(i)) begin
        n_fail++; $display("FAIL fill_byte%0d got=%h want=%h", i, wave_byte(rx_wave[base+i]), 8'(i));
      end
    end
  endtask

  task automatic test_reset_midframe;
    int t = 0;
    bit low_seen = 0;
    int base = rx_wave.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); data_in = 8'hA1 + 8'(i); data_in_valid = 1'b1;
      @(posedge clk); #1; data_in_valid = 1'b0;
    end
    wait_frames(base + 1, 100, "mid_frame1");
    while (txd !== 1'b0 && t < 20) begin @(posedge clk); #1; t++; end
    repeat (10) @(posedge clk); #1;
    n_chk++; if (tx_busy !== 1'b1 || fifo_level !== 5'd2) begin n_fail++; $display("FAIL mid_pre busy=%b level=%0d want 1/2", tx_busy, fifo_level); end
    reset = 1'b1; #1;
    n_chk++; if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL mid_async txd=%b busy=%b level=%0d want 1/0/0", txd, tx_busy, fifo_level);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (150) begin @(posedge clk); #1; if (txd !== 1'b1) low_seen = 1; end
    n_chk++; if (low_seen || rx_wave.size() != base + 1) begin n_fail++; $display("FAIL mid_quiet low=%0d frames=%0d want 0/1", low_seen, rx_wave.size() - base); end
    @(negedge clk); data_in = 8'h55; data_in_valid = 1'b1;
    @(posedge clk); #1; data_in_valid = 1'b0;
    wait_frames(base + 2, 100, "mid_resume");
    if (rx_wave.size() >= base + 2) begin
      n_chk++;
      if (wave_byte(rx_wave[base+1]) !== 8'h55) begin n_fail++; $display("FAIL mid_resume_byte got=%h want=55", wave_byte(rx_wave[base+1])); end
    end
  endtask

  task automatic test_wrap;
    int maxl = 0;
    int base = rx_wave.size();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); data_in = 8'(i*37 + 5); data_in_valid = 1'b1;
      @(posedge clk); #1; data_in_valid = 1'b0;
      if (fifo_level > maxl) maxl = fifo_level;
      repeat (44) begin @(posedge clk); #1; if (fifo_level > maxl) maxl = fifo_level; end
    end
    wait_frames(base + 40, 100, "wrap_frames");
    n_chk++; if (maxl > 1) begin n_fail++; $display("FAIL wrap_maxlevel got=%0d want<=1", maxl); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got=%b want=0", overflow); end
    for (int i = 0; i < 40 && base + i < rx_wave.size(); i++) begin
      n_chk++;
      if (rx_wave[base+i] !== frame_wave(8'(i*37 + 5))) begin
        n_fail++; $display("FAIL wrap_byte%0d got=%h want=%h", i, wave_byte(rx_wave[base+i]), 8'(i*37 + 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill_overflow();
    test_reset_midframe();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
